// File: rtl/gb_capture_ctrl_if.sv
// gb_capture_ctrl_if: Game Boy LCD inputs, framebuffer write port and buffer-status outputs
interface gb_capture_ctrl_if;
    logic [1:0]  GB_DAT;
    logic        GB_HSYNC;
    logic        GB_VSYNC;
    logic        GB_PX_CLK;
    logic        vga_vblank;
    logic [14:0] wr_addr;
    logic [1:0]  wr_data;
    logic        wr_en_0;
    logic        wr_en_1;
    logic        rd_sel;
    logic        swap;
    logic [14:0] px_per_frame;
    logic [7:0]  lines_per_frame;
    logic        frame_err;
    logic [7:0]  drop_cnt;

    modport master (
        output GB_DAT, GB_HSYNC, GB_VSYNC, GB_PX_CLK, vga_vblank,
        input  wr_addr, wr_data, wr_en_0, wr_en_1, rd_sel, swap,
               px_per_frame, lines_per_frame, frame_err, drop_cnt
    );

    modport slave (
        input  GB_DAT, GB_HSYNC, GB_VSYNC, GB_PX_CLK, vga_vblank,
        output wr_addr, wr_data, wr_en_0, wr_en_1, rd_sel, swap,
               px_per_frame, lines_per_frame, frame_err, drop_cnt
    );
endinterface

// File: rtl/gb_capture_ctrl.sv
// gb_capture_ctrl: oversampled Game Boy LCD capture into a double framebuffer,
// swapping to the VGA reader only on complete frames during VGA vertical blank.
module gb_capture_ctrl #(
    parameter int H_PIXELS    = 160,
    parameter int V_LINES     = 144,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK_25MHz,
    input  logic              reset_n,
    gb_capture_ctrl_if.slave  bus
);
    localparam logic [1:0]  SEEK = 2'd0, ARM = 2'd1, CAPTURE = 2'd2, DROP = 2'd3;
    localparam logic [14:0] FRAME_PX = 15'(H_PIXELS * V_LINES);
    localparam logic [7:0]  V_CNT = 8'(V_LINES);

    logic [SYNC_STAGES:0]        px_sr, hs_sr, vs_sr;
    logic [SYNC_STAGES-1:0][1:0] dat_sr;
    logic [1:0]  state;
    logic [14:0] addr, px_cnt;
    logic [7:0]  line_cnt;
    logic        ovf, wb, pending;
    logic        px_edge, hs_fall, vs_rise, accept, swap_now, wb_n, pend_n, good, room;
    logic [1:0]  dat;
    logic [14:0] px_inc;
    logic [7:0]  line_inc, drop_inc;

    // edges compare the last synchroniser flop with the one after it
    always_comb begin
        px_edge  = px_sr[SYNC_STAGES] & ~px_sr[SYNC_STAGES-1];
        hs_fall  = hs_sr[SYNC_STAGES] & ~hs_sr[SYNC_STAGES-1];
        vs_rise  = ~vs_sr[SYNC_STAGES] & vs_sr[SYNC_STAGES-1];
        accept   = px_edge & ~hs_sr[SYNC_STAGES-1];
        dat      = dat_sr[SYNC_STAGES-1];
        swap_now = pending & bus.vga_vblank;
        wb_n     = swap_now ? ~wb : wb;
        pend_n   = swap_now ? 1'b0 : pending;
        good     = (px_cnt == FRAME_PX) && !ovf && (line_cnt == V_CNT);
        room     = addr < FRAME_PX;
        px_inc   = (px_cnt == 15'h7FFF) ? px_cnt : px_cnt + 15'd1;
        line_inc = (line_cnt == 8'hFF) ? line_cnt : line_cnt + 8'd1;
        drop_inc = (bus.drop_cnt == 8'hFF) ? bus.drop_cnt : bus.drop_cnt + 8'd1;
    end

    always_ff @(posedge CLK_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            px_sr               <= '0;
            hs_sr               <= '0;
            vs_sr               <= '0;
            dat_sr              <= '0;
            state               <= SEEK;
            addr                <= '0;
            px_cnt              <= '0;
            line_cnt            <= '0;
            ovf                 <= 1'b0;
            wb                  <= 1'b0;
            pending             <= 1'b0;
            bus.rd_sel          <= 1'b1;
            bus.swap            <= 1'b0;
            bus.wr_en_0         <= 1'b0;
            bus.wr_en_1         <= 1'b0;
            bus.wr_addr         <= '0;
            bus.wr_data         <= '0;
            bus.px_per_frame    <= '0;
            bus.lines_per_frame <= '0;
            bus.frame_err       <= 1'b0;
            bus.drop_cnt        <= '0;
        end else begin
            px_sr       <= {px_sr[SYNC_STAGES-1:0], bus.GB_PX_CLK};
            hs_sr       <= {hs_sr[SYNC_STAGES-1:0], bus.GB_HSYNC};
            vs_sr       <= {vs_sr[SYNC_STAGES-1:0], bus.GB_VSYNC};
            dat_sr      <= {dat_sr[SYNC_STAGES-2:0], bus.GB_DAT};
            bus.wr_en_0 <= 1'b0;
            bus.wr_en_1 <= 1'b0;
            bus.swap    <= swap_now;
            wb          <= wb_n;
            pending     <= pend_n;
            if (swap_now)
                bus.rd_sel <= wb;
            case (state)
                SEEK: if (vs_rise) state <= ARM;
                ARM: begin
                    addr     <= '0;
                    px_cnt   <= '0;
                    line_cnt <= '0;
                    ovf      <= 1'b0;
                    if (!vs_rise && accept) begin
                        px_cnt <= 15'd1;
                        if (pend_n) begin
                            state        <= DROP;
                            bus.drop_cnt <= drop_inc;
                        end else begin
                            state       <= CAPTURE;
                            addr        <= 15'd1;
                            bus.wr_en_0 <= ~wb_n;
                            bus.wr_en_1 <= wb_n;
                            bus.wr_addr <= '0;
                            bus.wr_data <= dat;
                        end
                    end
                end
                default: begin
                    if (vs_rise) begin
                        bus.px_per_frame    <= px_cnt;
                        bus.lines_per_frame <= line_cnt;
                        state               <= ARM;
                        addr                <= '0;
                        px_cnt              <= '0;
                        line_cnt            <= '0;
                        ovf                 <= 1'b0;
                        if (state == CAPTURE) begin
                            bus.frame_err <= !good;
                            if (good)
                                pending <= 1'b1;
                        end
                    end else begin
                        if (hs_fall)
                            line_cnt <= line_inc;
                        if (accept) begin
                            px_cnt <= px_inc;
                            if (state == CAPTURE && room) begin
                                bus.wr_en_0 <= ~wb_n;
                                bus.wr_en_1 <= wb_n;
                                bus.wr_addr <= addr;
                                bus.wr_data <= dat;
                                addr        <= addr + 15'd1;
                            end else if (state == CAPTURE) begin
                                ovf <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gb_capture_ctrl.sv
// tb_gb_capture_ctrl: randomized GB frames against a frame-level model of the capture/swap rules
module tb_gb_capture_ctrl;
    localparam int H = 8, V = 6, HV = H * V;

    logic clk = 1'b0, reset_n = 1'b0;
    always #20 clk = ~clk;

    gb_capture_ctrl_if bus();
    gb_capture_ctrl #(.H_PIXELS(H), .V_LINES(V), .SYNC_STAGES(2)) dut (
        .CLK_25MHz(clk), .reset_n(reset_n), .bus(bus)
    );

    typedef struct {bit b; int a; int d;} wr_t;
    typedef enum {M_SEEK, M_ARM, M_CAP, M_DROP} mode_t;

    int checks = 0, failures = 0;
    wr_t obs[$], exp_q[$];
    int swap_seen = 0, both_seen = 0;
    mode_t mode;
    bit m_pend, m_wb, m_rd, m_err;
    int m_drop, m_px, m_ln, cur_tot, cur_lines;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (reset_n) begin
        if (bus.wr_en_0 || bus.wr_en_1) obs.push_back('{bus.wr_en_1, int'(bus.wr_addr), int'(bus.wr_data)});
        if (bus.wr_en_0 && bus.wr_en_1) both_seen++;
        if (bus.swap) swap_seen++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        mode = M_SEEK; m_pend = 0; m_wb = 0; m_rd = 1; m_err = 0;
        m_drop = 0; m_px = 0; m_ln = 0; cur_tot = 0; cur_lines = 0;
        obs.delete(); exp_q.delete();
    endtask

    task automatic check_reset_outputs();
        check("rst_wr_en_0", bus.wr_en_0, 0);
        check("rst_wr_en_1", bus.wr_en_1, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_rd_sel", bus.rd_sel, 1);
        check("rst_swap", bus.swap, 0);
        check("rst_px", bus.px_per_frame, 0);
        check("rst_lines", bus.lines_per_frame, 0);
        check("rst_err", bus.frame_err, 0);
        check("rst_drop", bus.drop_cnt, 0);
    endtask

    task automatic do_vsync();
        int mism = 0;
        int n = obs.size() < exp_q.size() ? obs.size() : exp_q.size();
        bit good;
        check("wr_cnt", obs.size(), exp_q.size());
        for (int i = 0; i < n; i++)
            if (obs[i].b != exp_q[i].b || obs[i].a != exp_q[i].a || obs[i].d != exp_q[i].d) mism++;
        check("wr_seq", mism, 0);
        check("wr_both", both_seen, 0);
        obs.delete(); exp_q.delete();
        bus.GB_VSYNC = 1; cyc(4);
        bus.GB_VSYNC = 0; cyc(10);
        if (mode == M_CAP || mode == M_DROP) begin
            m_px = cur_tot > 32767 ? 32767 : cur_tot;
            m_ln = cur_lines > 255 ? 255 : cur_lines;
            if (mode == M_CAP) begin
                good = (cur_tot == HV) && (cur_lines == V);
                m_err = !good;
                if (good) m_pend = 1;
            end
        end
        mode = M_ARM; cur_tot = 0; cur_lines = 0;
        check("px_per_frame", bus.px_per_frame, m_px);
        check("lines_per_frame", bus.lines_per_frame, m_ln);
        check("frame_err", bus.frame_err, m_err);
        check("drop_cnt", bus.drop_cnt, m_drop);
        check("rd_sel_vs", bus.rd_sel, m_rd);
    endtask

    task automatic do_vblank();
        int s0 = swap_seen;
        int exp_sw = m_pend ? 1 : 0;
        bus.vga_vblank = 1; cyc(3);
        bus.vga_vblank = 0; cyc(3);
        if (m_pend) begin m_rd = m_wb; m_wb = ~m_wb; m_pend = 0; end
        check("swap_pulses", swap_seen - s0, exp_sw);
        check("rd_sel_vb", bus.rd_sel, m_rd);
    endtask

    task automatic do_reset_mid();
        reset_n = 0; #1;
        check_reset_outputs();
        model_reset();
        cyc(3);
        reset_n = 1;
    endtask

    task automatic send_lines(input int l, input int h, input int rst_at = -1);
        int n = 0;
        int d;
        for (int ln = 0; ln < l; ln++) begin
            for (int p = 0; p < h; p++) begin
                if (n == rst_at) do_reset_mid();
                d = $urandom_range(0, 3);
                if (mode == M_ARM) begin
                    if (m_pend) begin mode = M_DROP; m_drop = m_drop < 255 ? m_drop + 1 : 255; end
                    else mode = M_CAP;
                end
                if (mode == M_CAP && cur_tot < HV) exp_q.push_back('{m_wb, cur_tot, d});
                if (mode == M_CAP || mode == M_DROP) cur_tot++;
                bus.GB_DAT = 2'(d); bus.GB_PX_CLK = 1; cyc(3);
                bus.GB_PX_CLK = 0; cyc(3);
                n++;
            end
            bus.GB_HSYNC = 1; cyc(4);
            bus.GB_HSYNC = 0; cyc(4);
            if (mode == M_CAP || mode == M_DROP) cur_lines++;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, l, h;
        bus.GB_DAT = 0; bus.GB_HSYNC = 0; bus.GB_VSYNC = 0; bus.GB_PX_CLK = 0; bus.vga_vblank = 0;
        model_reset();
        cyc(3);
        check_reset_outputs();
        reset_n = 1;
        cyc(3);
        do_vsync();
        send_lines(V, H); do_vsync(); do_vblank();
        send_lines(V, H); do_vsync();
        send_lines(V, H); do_vsync(); do_vblank();
        send_lines(V - 1, H); do_vsync(); do_vblank();
        send_lines(V, H + 1); do_vsync(); do_vblank();
        for (int k = 0; k < 10; k++) begin
            r = $urandom_range(0, 5);
            l = r == 0 ? V - 1 : r == 1 ? V + 1 : V;
            h = r == 2 ? H + 1 : r == 3 ? H - 1 : H;
            send_lines(l, h); do_vsync();
            if ($urandom_range(0, 1) == 1) do_vblank();
        end
        send_lines(V, H, 20); do_vsync();
        send_lines(V, H); do_vsync(); do_vblank();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gb_capture_ctrl.md
Name: gb_capture_ctrl

Overview:
- Sequences Game Boy LCD capture into the two 160x144x2-bit framebuffers, entirely in the 25 MHz VGA clock domain.
- Oversamples GB_PX_CLK, GB_HSYNC and GB_VSYNC, then generates write address, data and per-buffer write enables.
- Arbitrates the double buffer: a buffer is handed to the VGA reader only when a complete, well-formed frame exists, and only during VGA vertical blank.
- Publishes per-frame pixel and line counts for the on-screen debug bars.

Parameters:
- H_PIXELS, 160, active pixels per GB line
- V_LINES, 144, active lines per GB frame
- SYNC_STAGES, 2, synchroniser flops per GB input (minimum 2)

Ports:
- CLK_25MHz  in  1  system/VGA pixel clock
- reset_n  in  1  asynchronous, active-low reset
- GB_DAT  in  2  GB pixel data
- GB_HSYNC  in  1  GB line sync
- GB_VSYNC  in  1  GB frame sync
- GB_PX_CLK  in  1  GB pixel clock, ~4 MHz
- vga_vblank  in  1  high while the VGA timing is in vertical blank; synchronous to CLK_25MHz
- wr_addr  out  15  framebuffer write address
- wr_data  out  2  framebuffer write data
- wr_en_0  out  1  single-cycle write strobe, buffer 0
- wr_en_1  out  1  single-cycle write strobe, buffer 1
- rd_sel  out  1  buffer the VGA reader must use
- swap  out  1  one-cycle pulse when rd_sel changes
- px_per_frame  out  15  pixels accepted in the last completed frame
- lines_per_frame  out  8  HSYNC falling edges in the last completed frame
- frame_err  out  1  high if the last completed frame was malformed
- drop_cnt  out  8  frames dropped, saturates at 255

Behaviour:
- Reset (async assert, sync release): all sync flops 0; state SEEK; wr_en_0 = 0, wr_en_1 = 0; wr_addr = 0; wr_data = 0; write buffer wb = 0; rd_sel = 1; pending = 0; swap = 0; all counts = 0; frame_err = 0; drop_cnt = 0.
- Synchronisers:
  - GB_DAT passes through the same SYNC_STAGES chain as GB_PX_CLK.
  - Edges are detected from the last sync flop and the flop after it.
  - px_edge = falling edge of GB_PX_CLK. hs_fall = falling edge of GB_HSYNC. vs_rise = rising edge of GB_VSYNC.
- Pixel acceptance: on px_edge with synced hsync = 0. The sampled data is the synced GB_DAT on that same cycle.
- Write latency: wr_en_x, wr_addr and wr_data are registered and appear 1 cycle after px_edge. wr_en is high for exactly 1 cycle, and only the strobe for buffer wb is asserted.
- Address generation:
  - Incremental counter, no multiply. Reset to 0 at frame start; +1 per written pixel.
  - At H_PIXELS*V_LINES (23040) further writes are suppressed and the overflow flag is set.
- State machine:
  - SEEK: ignore everything until vs_rise, then go to ARM.
  - ARM: addr = 0, pixel count = 0, line count = 0. On the first accepted pixel: if pending = 0, go to CAPTURE and write that pixel; if pending = 1, go to DROP, where nothing is written for this frame (the published frame is protected) and drop_cnt increments. A vs_rise while in ARM stays in ARM with counts cleared.
  - CAPTURE: write accepted pixels; increment line count on hs_fall.
  - DROP: count pixels and lines only, no writes.
  - On vs_rise from CAPTURE or DROP: latch px_per_frame and lines_per_frame, then go to ARM.
- Frame evaluation (on vs_rise, from CAPTURE only):
  - The frame is good iff pixel count = 23040, no overflow, and line count = V_LINES.
  - Good frame: pending <= 1, frame_err <= 0.
  - Bad frame: frame_err <= 1, pending unchanged.
  - From DROP: frame_err is not updated.
- Swap: when pending = 1 and vga_vblank = 1, in one cycle: rd_sel <= wb, wb <= ~wb, pending <= 0, swap = 1 for that cycle.
- Invariant: rd_sel != wb at all times except the reset state (wb = 0, rd_sel = 1 satisfies it).
- Simultaneous events:
  - Swap and vs_rise in the same cycle: swap uses the old pending; the frame evaluation may then set pending for the new wb.
  - Swap and first pixel in the same cycle: swap wins, and ARM sees pending = 0 and the new wb.
- Arithmetic: counts saturate and never wrap (pixels at 0x7FFF, lines at 255, drop_cnt at 255).
- Reset mid-frame: everything returns to reset values; capture resumes at the next vs_rise; no write strobe is issued during or after the reset assertion until a new frame starts.

Test Plan:
- Reset, then a clean 160x144 GB frame followed by vs_rise → 23040 wr_en_0 pulses, wr_addr 0..23039 in order, pending = 1, frame_err = 0, px_per_frame = 23040, lines_per_frame = 144.
- Good frame then vga_vblank = 1 → swap pulses for 1 cycle, rd_sel 1→0, wb = 1; the next frame writes only via wr_en_1.
- Two good frames with vga_vblank held 0 → second frame wr_en_0 and wr_en_1 both stay 0, drop_cnt = 1, rd_sel unchanged; vblank then swaps to buffer 0 contents.
- Frame of 160x143 (short) → frame_err = 1, pending stays 0, lines_per_frame = 143, no swap on vblank.
- Frame with 23100 pixels → exactly 23040 writes, then none; frame_err = 1.
- Deassert reset_n mid-CAPTURE at pixel 5000 → outputs go to reset values immediately; no strobes until the frame after the next vs_rise; rd_sel = 1.
